// File: rtl/scale_pkg.sv
// Shared types and helpers for the scaler mode scheduler.
package scale_pkg;

  localparam int unsigned MODE_W = 3;

  typedef logic [MODE_W-1:0] mode_t;

  localparam mode_t MODE_0 = 3'b001;
  localparam mode_t MODE_1 = 3'b010;
  localparam mode_t MODE_2 = 3'b100;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VS,
    CFG,
    HOLD
  } state_t;

  // Rotate one-hot mode 001 -> 010 -> 100 -> 001; non-one-hot falls back to MODE_0.
  function automatic mode_t next_mode(input mode_t m);
    case (m)
      MODE_0:  return MODE_1;
      MODE_1:  return MODE_2;
      default: return MODE_0;
    endcase
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Touch key synchronizer and debouncer producing one pulse per press.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 500000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key,
  output logic press_evt
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYC + 1);

  logic          key_meta;
  logic          key_sync;
  logic [CW-1:0] cnt;

  // Two-flop synchronizer; the released (high) level is the reset value.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_meta <= 1'b1;
      key_sync <= 1'b1;
    end else begin
      key_meta <= key;
      key_sync <= key_meta;
    end
  end

  // Saturating low-time counter; pulse on the cycle it reaches the threshold.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt       <= '0;
      press_evt <= 1'b0;
    end else if (key_sync) begin
      cnt       <= '0;
      press_evt <= 1'b0;
    end else begin
      press_evt <= (cnt == CW'(DEBOUNCE_CYC - 1));
      if (cnt != CW'(DEBOUNCE_CYC)) cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/scale_mode_sched.sv
// Frame-synchronous scaler mode scheduler: key rotation, vsync-aligned
// config handshake and post-change output blanking.
module scale_mode_sched
  import scale_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 500000,
  parameter int unsigned VS_TIMEOUT   = 2500000,
  parameter int unsigned BLANK_FRAMES = 2,
  parameter mode_t       RESET_MODE   = 3'b100
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        touch_key,
  input  logic        vs_in,
  input  logic        cfg_ready,
  output logic        cfg_valid,
  output logic [2:0]  cfg_mode,
  output logic [2:0]  active_mode,
  output logic        blank_en,
  output logic        busy
);

  localparam int unsigned TW = (VS_TIMEOUT < 2) ? 1 : $clog2(VS_TIMEOUT);
  localparam int unsigned FW = (BLANK_FRAMES < 1) ? 1 : $clog2(BLANK_FRAMES + 1);

  state_t        state;
  mode_t         target;
  logic          queued;
  logic [TW-1:0] to_cnt;
  logic [FW-1:0] frm_cnt;
  logic          vs_meta;
  logic          vs_sync;
  logic          vs_prev;
  logic          press_evt;
  logic          vs_rise;
  logic          frame_tick;
  logic          queue_hit;
  mode_t         tgt_step;

  key_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_deb (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key       (touch_key),
    .press_evt (press_evt)
  );

  // Vsync synchronizer plus one delay stage for rising-edge detection.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vs_meta <= 1'b0;
      vs_sync <= 1'b0;
      vs_prev <= 1'b0;
    end else begin
      vs_meta <= vs_in;
      vs_sync <= vs_meta;
      vs_prev <= vs_sync;
    end
  end

  assign vs_rise    = vs_sync & ~vs_prev;
  assign frame_tick = vs_rise | (to_cnt == TW'(VS_TIMEOUT - 1));
  assign queue_hit  = queued | press_evt;
  assign tgt_step   = press_evt ? next_mode(target) : target;

  // Scheduler FSM; the timeout counter restarts on every frame tick and state entry.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      target      <= RESET_MODE;
      active_mode <= RESET_MODE;
      cfg_mode    <= RESET_MODE;
      cfg_valid   <= 1'b0;
      blank_en    <= 1'b0;
      busy        <= 1'b0;
      queued      <= 1'b0;
      frm_cnt     <= '0;
      to_cnt      <= '0;
    end else begin
      to_cnt <= frame_tick ? '0 : to_cnt + TW'(1);
      case (state)
        IDLE: begin
          if (press_evt) begin
            target <= next_mode(active_mode);
            state  <= WAIT_VS;
            busy   <= 1'b1;
            to_cnt <= '0;
          end
        end
        WAIT_VS: begin
          target <= tgt_step;
          if (press_evt && (tgt_step == active_mode)) begin
            state  <= IDLE;
            busy   <= 1'b0;
            to_cnt <= '0;
          end else if (frame_tick) begin
            cfg_mode  <= tgt_step;
            cfg_valid <= 1'b1;
            state     <= CFG;
            to_cnt    <= '0;
          end
        end
        CFG: begin
          if (press_evt) queued <= 1'b1;
          if (cfg_ready) begin
            active_mode <= cfg_mode;
            cfg_valid   <= 1'b0;
            to_cnt      <= '0;
            if (BLANK_FRAMES != 0) begin
              state    <= HOLD;
              blank_en <= 1'b1;
              frm_cnt  <= '0;
            end else if (queue_hit) begin
              state  <= WAIT_VS;
              target <= next_mode(cfg_mode);
              queued <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (press_evt) queued <= 1'b1;
          if (frm_cnt == FW'(BLANK_FRAMES)) begin
            blank_en <= 1'b0;
            to_cnt   <= '0;
            queued   <= 1'b0;
            if (queue_hit) begin
              state  <= WAIT_VS;
              target <= next_mode(active_mode);
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (frame_tick) begin
            frm_cnt <= frm_cnt + FW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scale_mode_sched.sv
// Directed bench for scale_mode_sched with a handshake scoreboard.
module tb_scale_mode_sched;
  import scale_pkg::*;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       touch_key;
  logic       vs_in;
  logic       cfg_ready;
  logic       cfg_valid;
  logic [2:0] cfg_mode;
  logic [2:0] active_mode;
  logic       blank_en;
  logic       busy;

  int         errors = 0;
  int         checks = 0;
  int         hs_cnt = 0;
  logic       vs_en  = 1'b1;
  logic [2:0] exp_q[$];
  logic [2:0] mon_exp;

  scale_mode_sched #(
    .DEBOUNCE_CYC (16),
    .VS_TIMEOUT   (200),
    .BLANK_FRAMES (2),
    .RESET_MODE   (3'b100)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .touch_key   (touch_key),
    .vs_in       (vs_in),
    .cfg_ready   (cfg_ready),
    .cfg_valid   (cfg_valid),
    .cfg_mode    (cfg_mode),
    .active_mode (active_mode),
    .blank_en    (blank_en),
    .busy        (busy)
  );

  always #10 sys_clk = ~sys_clk;

  // Vsync source: 4-cycle pulse every 100 cycles while enabled.
  initial begin
    vs_in = 1'b0;
    forever begin
      repeat (96) @(negedge sys_clk);
      if (vs_en) vs_in = 1'b1;
      repeat (4) @(negedge sys_clk);
      vs_in = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every accepted config transaction must match the next queued mode.
  always begin
    @(negedge sys_clk);
    #1;
    if (sys_rst_n && cfg_valid && cfg_ready) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        check("cfg_unexpected", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_exp = exp_q.pop_front();
        check("cfg_mode_hs", 32'(cfg_mode), 32'(mon_exp));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic press();
    touch_key = 1'b0;
    cyc(20);
    touch_key = 1'b1;
    cyc(5);
  endtask

  task automatic press_and_wait(input int low, output int t_busy, output int t_valid);
    t_busy    = -1;
    t_valid   = -1;
    touch_key = 1'b0;
    for (int i = 1; i <= 700; i++) begin
      if (i == low + 1) touch_key = 1'b1;
      @(negedge sys_clk);
      if (busy && t_busy < 0) t_busy = i;
      if (cfg_valid) begin
        t_valid = i;
        break;
      end
    end
    touch_key = 1'b1;
  endtask

  task automatic wait_vs_rise();
    logic prev;
    logic seen;
    prev = vs_in;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge sys_clk);
      seen = vs_in && !prev;
      prev = vs_in;
    end
    check("vs_rise_seen", 32'(seen), 32'd1);
  endtask

  task automatic wait_valid(input int limit);
    for (int i = 0; i < limit && !cfg_valid; i++) @(negedge sys_clk);
    check("valid_seen", 32'(cfg_valid), 32'd1);
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit && busy; i++) @(negedge sys_clk);
    check("idle_reached", 32'(busy), 32'd0);
  endtask

  task automatic measure_blank(output int len);
    len = 0;
    while (blank_en && len < 1000) begin
      len++;
      @(negedge sys_clk);
    end
  endtask

  initial begin
    int t_busy;
    int t_valid;
    int len;
    int hs0;
    logic stable;
    logic saw_busy;

    touch_key = 1'b1;
    cfg_ready = 1'b1;
    sys_rst_n = 1'b0;
    cyc(3);

    // Reset state
    check("rst_cfg_valid", 32'(cfg_valid), 32'd0);
    check("rst_cfg_mode", 32'(cfg_mode), 32'(MODE_2));
    check("rst_active", 32'(active_mode), 32'(MODE_2));
    check("rst_blank", 32'(blank_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    sys_rst_n = 1'b1;
    cyc(2);

    // Held key: one press, applied at the next frame, then two blank frames
    exp_q.push_back(MODE_0);
    press_and_wait(40, t_busy, t_valid);
    check("t1_valid_seen", 32'(t_valid > 0), 32'd1);
    check("t1_cfg_mode", 32'(cfg_mode), 32'(MODE_0));
    check("t1_active_before", 32'(active_mode), 32'(MODE_2));
    cyc(1);
    check("t1_active_after", 32'(active_mode), 32'(MODE_0));
    check("t1_valid_drop", 32'(cfg_valid), 32'd0);
    check("t1_blank_on", 32'(blank_en), 32'd1);
    measure_blank(len);
    check("t1_blank_len", 32'(len), 32'd200);
    wait_idle(50);
    check("t1_active_final", 32'(active_mode), 32'(MODE_0));

    // Three presses in one frame wrap back to the active mode: no transaction
    hs0 = hs_cnt;
    wait_vs_rise();
    cyc(5);
    press();
    check("t3_busy_after_first", 32'(busy), 32'd1);
    press();
    press();
    cyc(2);
    check("t3_idle", 32'(busy), 32'd0);
    cyc(250);
    check("t3_no_cfg", 32'(hs_cnt), 32'(hs0));
    check("t3_active", 32'(active_mode), 32'(MODE_0));

    // Backpressure: offer held stable while cfg_ready is low
    cfg_ready = 1'b0;
    exp_q.push_back(MODE_1);
    press_and_wait(20, t_busy, t_valid);
    check("t4_valid_seen", 32'(t_valid > 0), 32'd1);
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      cyc(1);
      if (!(cfg_valid === 1'b1 && cfg_mode === MODE_1)) stable = 1'b0;
    end
    check("t4_offer_stable", 32'(stable), 32'd1);
    check("t4_active_held", 32'(active_mode), 32'(MODE_0));
    cfg_ready = 1'b1;
    cyc(1);
    check("t4_active_update", 32'(active_mode), 32'(MODE_1));
    check("t4_valid_drop", 32'(cfg_valid), 32'd0);
    wait_idle(600);

    // Reset during CFG abandons the change
    cfg_ready = 1'b0;
    wait_vs_rise();
    cyc(5);
    press();
    press();
    wait_valid(300);
    check("t7_cfg_mode", 32'(cfg_mode), 32'(MODE_0));
    cyc(3);
    sys_rst_n = 1'b0;
    #1;
    check("t7_rst_valid", 32'(cfg_valid), 32'd0);
    check("t7_rst_active", 32'(active_mode), 32'(MODE_2));
    check("t7_rst_busy", 32'(busy), 32'd0);
    check("t7_rst_cfg_mode", 32'(cfg_mode), 32'(MODE_2));
    cyc(2);
    sys_rst_n = 1'b1;
    cfg_ready = 1'b1;
    hs0 = hs_cnt;
    cyc(200);
    check("t7_no_cfg", 32'(hs_cnt), 32'(hs0));
    check("t7_active", 32'(active_mode), 32'(MODE_2));

    // Short glitch is not a press
    hs0 = hs_cnt;
    touch_key = 1'b0;
    cyc(10);
    touch_key = 1'b1;
    saw_busy = 1'b0;
    for (int i = 0; i < 300; i++) begin
      cyc(1);
      if (busy) saw_busy = 1'b1;
    end
    check("t2_never_busy", 32'(saw_busy), 32'd0);
    check("t2_active", 32'(active_mode), 32'(MODE_2));
    check("t2_no_cfg", 32'(hs_cnt), 32'(hs0));

    // Vsync stuck low: timeout forces frame boundaries
    vs_en = 1'b0;
    cyc(110);
    exp_q.push_back(MODE_0);
    press_and_wait(20, t_busy, t_valid);
    check("t5_busy_seen", 32'(t_busy > 0), 32'd1);
    check("t5_timeout_latency", 32'(t_valid - t_busy), 32'd200);
    cyc(1);
    check("t5_active", 32'(active_mode), 32'(MODE_0));
    check("t5_blank_on", 32'(blank_en), 32'd1);
    measure_blank(len);
    check("t5_blank_len", 32'(len), 32'd401);
    wait_idle(50);

    // Two presses during HOLD queue a single follow-up change
    vs_en = 1'b1;
    exp_q.push_back(MODE_1);
    press_and_wait(20, t_busy, t_valid);
    check("t6_valid_seen", 32'(t_valid > 0), 32'd1);
    cyc(2);
    check("t6_blank_on", 32'(blank_en), 32'd1);
    check("t6_active_first", 32'(active_mode), 32'(MODE_1));
    exp_q.push_back(MODE_2);
    press();
    press();
    wait_idle(1000);
    check("t6_active_final", 32'(active_mode), 32'(MODE_2));
    hs0 = hs_cnt;
    cyc(300);
    check("t6_no_extra_cfg", 32'(hs_cnt), 32'(hs0));
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
